muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its own control FSM, placed in the EX stage beside the ALU.
- Decodes the R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO function codes, runs a shift-add multiply or restoring divide over WIDTH cycles, and owns the HI/LO registers.
- Drives busy to the hazard unit so the pipeline stalls on MFHI/MFLO and on further mul/div ops.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count per operation.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- alu_op  in  2  EX-stage ALUOp; only 2'b10 (R-type) is decoded
- funct  in  6  EX-stage function field
- ex_valid  in  1  EX instruction valid (not bubble, not stalled)
- abort  in  1  exception/flush; cancels an in-flight operation
- rs_val  in  WIDTH  operand A (dividend / multiplicand, MTHI/MTLO source)
- rt_val  in  WIDTH  operand B (divisor / multiplier)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- One clock, synchronous active-high reset.
- Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards all progress.
- Decode applies only when ex_valid=1 and alu_op=2'b10:
  - 011000 MULT (signed)
  - 011001 MULTU
  - 011010 DIV (signed)
  - 011011 DIVU
  - 010001 MTHI
  - 010011 MTLO
  - Any other code causes no action.
- States:
  - IDLE -> CALC on an accepted start: operands captured, signs recorded, magnitudes taken for signed ops, counter=0.
  - CALC: one iteration per cycle; counter increments; exits to FIX when counter=WIDTH-1.
  - FIX: sign correction; hi/lo written; -> IDLE; done=1 in the following cycle.
- Latency:
  - Start sampled at edge 0.
  - busy=1 from edge 0 through edge WIDTH+1, i.e. WIDTH+1 cycles (33 for WIDTH=32).
  - hi/lo and done are valid after edge WIDTH+1.
  - busy = (state != IDLE), registered.
- Multiply: 2*WIDTH product accumulator; hi = upper word, lo = lower word. Signed result = two's-complement negate of the 2*WIDTH magnitude product if the operand signs differ.
- Divide (restoring): lo = quotient, hi = remainder. Signed: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = rs_val. The full latency still applies.
- Signed overflow (most-negative / -1): lo = most-negative value, hi = 0.
- Start while busy: ignored; operation continues. The hazard unit guarantees a stall.
- MTHI/MTLO in IDLE: written at the next edge; done is not asserted. While busy: ignored.
- Start accepted in the same cycle done=1: allowed; FSM is in IDLE.
- abort while busy: -> IDLE next edge, hi/lo unchanged, no done pulse. abort in IDLE suppresses any start or MT write that cycle.

Decomposition:
- Shared package:
  - funct code constants: FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MTHI, FN_MTLO, FN_MFHI, FN_MFLO
  - ALUOP_RTYPE constant
  - FSM state enum (IDLE, CALC, FIX)
- One sub-module, muldiv_datapath: accumulator, shift, add/subtract and negate logic, under control-strobe interface (load, step, fix, is_div, neg_q, neg_r).
- FSM, decode and HI/LO registers stay in muldiv_sequencer.

Test Plan:
- MULT rs=7, rt=6 -> busy 33 cycles, done pulse, hi=0x00000000, lo=0x0000002A.
- MULT rs=0xFFFFFFFF, rt=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x00001234 after full latency.
- MULT started; a second MULT presented at cycle 5; abort at cycle 10 -> second op ignored, busy drops after edge 11, no done, hi/lo keep prior values.
- MTLO rs=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next cycle, done=0. Reset asserted mid-DIV -> busy=0, hi=lo=0 next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared funct codes, ALUOp and FSM state for the mul/div unit
package muldiv_pkg;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiply / restoring divide accumulator with sign fix-up
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic             is_div,
  input  logic             neg_q,
  input  logic             neg_r,
  input  logic             a_neg,
  input  logic             b_neg,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd, a_mag, b_mag, diff, prod_hi_neg;
  logic [WIDTH:0] sum, rem_sh;
  logic div_r, nq_r, nr_r, ge;
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign rem_sh = {acc_hi, acc_lo[WIDTH-1]};
  // Compare on the full WIDTH+1 value so a zero divisor still yields all-ones quotient
  assign ge = rem_sh >= {1'b0, opnd};
  assign diff = rem_sh[WIDTH-1:0] - opnd;
  assign prod_hi_neg = ~acc_hi + WIDTH'(acc_lo == '0);
  assign res_lo = (fix && nq_r) ? -acc_lo : acc_lo;
  assign res_hi = !fix ? acc_hi :
                  div_r ? (nr_r ? -acc_hi : acc_hi) :
                  (nq_r ? prod_hi_neg : acc_hi);
  always_ff @(posedge clk) begin
    if (load) begin
      acc_hi <= '0;
      acc_lo <= is_div ? a_mag : b_mag;
      opnd <= is_div ? b_mag : a_mag;
      div_r <= is_div;
      nq_r <= neg_q;
      nr_r <= neg_r;
    end else if (step) begin
      if (div_r) begin
        acc_hi <= ge ? diff : rem_sh[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], ge};
      end else begin
        {acc_hi, acc_lo} <= {sum, acc_lo[WIDTH-1:1]};
      end
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: decode, control FSM and HI/LO registers of the iterative mul/div unit
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             ex_valid,
  input  logic             abort,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic dec, start, load, step, fix, is_div_op, sgn, a_neg, b_neg, neg_q, neg_r, wr_hi, wr_lo;
  assign dec = ex_valid && alu_op == ALUOP_RTYPE && !abort && state == IDLE;
  assign is_div_op = funct == FN_DIV || funct == FN_DIVU;
  assign sgn = funct == FN_MULT || funct == FN_DIV;
  assign start = dec && (funct == FN_MULT || funct == FN_MULTU || is_div_op);
  assign a_neg = sgn && rs_val[WIDTH-1];
  assign b_neg = sgn && rt_val[WIDTH-1];
  // A zero divisor keeps the raw all-ones quotient; the remainder sign fix restores rs_val
  assign neg_q = (a_neg ^ b_neg) && !(is_div_op && rt_val == '0);
  assign neg_r = is_div_op && a_neg;
  assign load = start;
  assign step = state == CALC && !abort;
  assign fix = state == FIX && !abort;
  assign wr_hi = fix || (dec && funct == FN_MTHI);
  assign wr_lo = fix || (dec && funct == FN_MTLO);
  always_comb begin
    state_nx = state;
    state_nx = (state != IDLE && abort) ? IDLE :
               state == IDLE ? (start ? CALC : IDLE) :
               state == CALC ? (cnt == CW'(WIDTH-1) ? FIX : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_nx;
      busy <= state_nx != IDLE;
      done <= fix;
      cnt <= load ? '0 : step ? cnt + 1'b1 : cnt;
      if (wr_hi) hi <= fix ? res_hi : rs_val;
      if (wr_lo) lo <= fix ? res_lo : rs_val;
    end
  end
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .load(load),
    .step(step),
    .fix(fix),
    .is_div(is_div_op),
    .neg_q(neg_q),
    .neg_r(neg_r),
    .a_neg(a_neg),
    .b_neg(b_neg),
    .a(rs_val),
    .b(rt_val),
    .res_hi(res_hi),
    .res_lo(res_lo)
  );
endmodule
